// File: rtl/sc_speedscheduler_if.sv
// Event, level and strobe bundle between the game logic, the speed scheduler and the up-speed counter.
interface sc_speedscheduler_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic                 SC_SPEEDSCHEDULER_start_InLow;
  logic                 SC_SPEEDSCHEDULER_levelup_InLow;
  logic                 SC_SPEEDSCHEDULER_gameover_InLow;
  logic                 SC_SPEEDSCHEDULER_pause_InLow;
  logic [DATAWIDTH-1:0] SC_SPEEDSCHEDULER_level_InBUS;
  logic                 SC_SPEEDSCHEDULER_upcount_OutLow;
  logic                 SC_SPEEDSCHEDULER_clear_OutLow;
  logic                 SC_SPEEDSCHEDULER_tick_OutHigh;
  logic                 SC_SPEEDSCHEDULER_maxlevel_OutHigh;
  logic [2:0]           SC_SPEEDSCHEDULER_state_OutBUS;

  modport master (
    output SC_SPEEDSCHEDULER_start_InLow, SC_SPEEDSCHEDULER_levelup_InLow,
           SC_SPEEDSCHEDULER_gameover_InLow, SC_SPEEDSCHEDULER_pause_InLow,
           SC_SPEEDSCHEDULER_level_InBUS,
    input  SC_SPEEDSCHEDULER_upcount_OutLow, SC_SPEEDSCHEDULER_clear_OutLow,
           SC_SPEEDSCHEDULER_tick_OutHigh, SC_SPEEDSCHEDULER_maxlevel_OutHigh,
           SC_SPEEDSCHEDULER_state_OutBUS
  );

  modport slave (
    input  SC_SPEEDSCHEDULER_start_InLow, SC_SPEEDSCHEDULER_levelup_InLow,
           SC_SPEEDSCHEDULER_gameover_InLow, SC_SPEEDSCHEDULER_pause_InLow,
           SC_SPEEDSCHEDULER_level_InBUS,
    output SC_SPEEDSCHEDULER_upcount_OutLow, SC_SPEEDSCHEDULER_clear_OutLow,
           SC_SPEEDSCHEDULER_tick_OutHigh, SC_SPEEDSCHEDULER_maxlevel_OutHigh,
           SC_SPEEDSCHEDULER_state_OutBUS
  );
endinterface

// File: rtl/sc_speedscheduler.sv
// Frogger game-speed controller: drives the up-speed counter and emits level-dependent lane ticks.
// Optional SC_SPEEDSCHEDULER_WRAP_EN: level-up at MAX_LEVEL clears the counter and keeps running.
module sc_speedscheduler #(
  parameter int unsigned BASE_PERIOD     = 25_000_000,
  parameter int unsigned PERIOD_STEP     = 2_000_000,
  parameter int unsigned MIN_PERIOD      = 2_500_000,
  parameter int unsigned MAX_LEVEL       = 8,
  parameter int unsigned DATAWIDTH       = 8,
  parameter int unsigned PRESCALER_WIDTH = 26
) (
  input  logic                SC_SPEEDSCHEDULER_CLOCK_50,
  input  logic                SC_SPEEDSCHEDULER_RESET_InHigh,
  sc_speedscheduler_if.slave  bus
);

  localparam int unsigned CW = PRESCALER_WIDTH + DATAWIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    RUN     = 3'b001,
    PAUSE   = 3'b010,
    LEVELUP = 3'b011,
`ifdef SC_SPEEDSCHEDULER_WRAP_EN
    CLEAR   = 3'b100,
    WRAP    = 3'b101
`else
    CLEAR   = 3'b100
`endif
  } state_t;

  state_t                     state, stateNext;
  logic [PRESCALER_WIDTH-1:0] count, countNext;
  logic [PRESCALER_WIDTH-1:0] period, periodLast;
  logic signed [CW-1:0]       periodWide;
  logic                       atMax;

  // Wide signed subtraction so a large level saturates to the floor instead of wrapping.
  always_comb begin
    periodWide = $signed(CW'(BASE_PERIOD)) -
                 $signed(CW'(bus.SC_SPEEDSCHEDULER_level_InBUS) * CW'(PERIOD_STEP));
    if (periodWide < $signed(CW'(MIN_PERIOD)))
      period = PRESCALER_WIDTH'(MIN_PERIOD);
    else
      period = periodWide[PRESCALER_WIDTH-1:0];
    periodLast = period - PRESCALER_WIDTH'(1);
    atMax      = (bus.SC_SPEEDSCHEDULER_level_InBUS >= DATAWIDTH'(MAX_LEVEL));
  end

  always_ff @(posedge SC_SPEEDSCHEDULER_CLOCK_50 or posedge SC_SPEEDSCHEDULER_RESET_InHigh) begin
    if (SC_SPEEDSCHEDULER_RESET_InHigh) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      IDLE: begin
        if (!bus.SC_SPEEDSCHEDULER_start_InLow) begin
          stateNext = RUN;
          countNext = '0;
        end
      end
      RUN: begin
        if (!bus.SC_SPEEDSCHEDULER_gameover_InLow)
          stateNext = CLEAR;
        else if (!bus.SC_SPEEDSCHEDULER_levelup_InLow && !atMax)
          stateNext = LEVELUP;
`ifdef SC_SPEEDSCHEDULER_WRAP_EN
        else if (!bus.SC_SPEEDSCHEDULER_levelup_InLow)
          stateNext = WRAP;
`endif
        else if (!bus.SC_SPEEDSCHEDULER_pause_InLow)
          stateNext = PAUSE;
        // ">=" also catches a count stranded above a freshly shortened period (no tick then).
        else if (count >= periodLast)
          countNext = '0;
        else
          countNext = count + PRESCALER_WIDTH'(1);
      end
      PAUSE: begin
        if (!bus.SC_SPEEDSCHEDULER_gameover_InLow)
          stateNext = CLEAR;
        else if (bus.SC_SPEEDSCHEDULER_pause_InLow)
          stateNext = RUN;
      end
      LEVELUP: begin
        stateNext = RUN;
        countNext = '0;
      end
      CLEAR: begin
        stateNext = IDLE;
        countNext = '0;
      end
`ifdef SC_SPEEDSCHEDULER_WRAP_EN
      WRAP: begin
        stateNext = RUN;
        countNext = '0;
      end
`endif
      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase
  end

  always_comb begin
    bus.SC_SPEEDSCHEDULER_upcount_OutLow   = (state != LEVELUP);
`ifdef SC_SPEEDSCHEDULER_WRAP_EN
    bus.SC_SPEEDSCHEDULER_clear_OutLow     = !((state == CLEAR) || (state == WRAP));
`else
    bus.SC_SPEEDSCHEDULER_clear_OutLow     = (state != CLEAR);
`endif
    bus.SC_SPEEDSCHEDULER_tick_OutHigh     = (state == RUN) && (count == periodLast);
    bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh = atMax;
    bus.SC_SPEEDSCHEDULER_state_OutBUS     = state;
  end

endmodule

// File: tb/tb_sc_speedscheduler.sv
// Directed bench for sc_speedscheduler with a behavioural up-speed counter closing the loop.
module tb_sc_speedscheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cntRst = 1'b1;
  logic [7:0] levelCnt;
  int         asserts = 0;
  int         fails = 0;

  sc_speedscheduler_if #(.DATAWIDTH(8)) bus ();

  sc_speedscheduler #(
    .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4),
    .MAX_LEVEL(3), .DATAWIDTH(8), .PRESCALER_WIDTH(8)
  ) dut (
    .SC_SPEEDSCHEDULER_CLOCK_50(clk),
    .SC_SPEEDSCHEDULER_RESET_InHigh(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Up-speed counter model; its own reset so a scheduler reset leaves the level alone.
  always_ff @(posedge clk or posedge cntRst) begin
    if (cntRst) levelCnt <= '0;
    else if (!bus.SC_SPEEDSCHEDULER_clear_OutLow) levelCnt <= '0;
    else if (!bus.SC_SPEEDSCHEDULER_upcount_OutLow) levelCnt <= levelCnt + 8'd1;
  end
  assign bus.SC_SPEEDSCHEDULER_level_InBUS = levelCnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b1;
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
    bus.SC_SPEEDSCHEDULER_gameover_InLow = 1'b1;
    bus.SC_SPEEDSCHEDULER_pause_InLow = 1'b1;
    rst = 1'b1; cntRst = 1'b1;
    @(negedge clk);
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b000) begin fails++; $display("FAIL reset_state got %b want 000", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL reset_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_clear_OutLow !== 1'b1) begin fails++; $display("FAIL reset_clear got %b want 1", bus.SC_SPEEDSCHEDULER_clear_OutLow); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", bus.SC_SPEEDSCHEDULER_tick_OutHigh); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh !== 1'b0) begin fails++; $display("FAIL reset_maxlevel got %b want 0", bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh); end
    rst = 1'b0; cntRst = 1'b0;
    @(negedge clk);
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b000) begin fails++; $display("FAIL post_reset_state got %b want 000", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
  endtask

  task automatic test_start_period();
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b1;
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b001) begin fails++; $display("FAIL start_state got %b want 001", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) @(negedge clk);
      asserts++;
      if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== ((i % 10) == 0)) begin
        fails++; $display("FAIL period10_tick cycle %0d got %b want %b", i, bus.SC_SPEEDSCHEDULER_tick_OutHigh, (i % 10) == 0);
      end
    end
  endtask

  task automatic test_levelup();
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b011) begin fails++; $display("FAIL levelup_state got %b want 011", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b0) begin fails++; $display("FAIL levelup_upcount got %b want 0", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    @(negedge clk);
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b001) begin fails++; $display("FAIL levelup_back_run got %b want 001", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL levelup_upcount_width got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    asserts++; if (levelCnt !== 8'd1) begin fails++; $display("FAIL levelup_level got %0d want 1", levelCnt); end
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      asserts++;
      if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== ((i % 8) == 0)) begin
        fails++; $display("FAIL period8_tick cycle %0d got %b want %b", i, bus.SC_SPEEDSCHEDULER_tick_OutHigh, (i % 8) == 0);
      end
    end
  endtask

  task automatic test_maxlevel();
    for (int n = 0; n < 2; n++) begin
      bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
      @(negedge clk);
      bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
      asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b0) begin fails++; $display("FAIL climb_upcount step %0d got %b want 0", n, bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
      @(negedge clk);
    end
    asserts++; if (levelCnt !== 8'd3) begin fails++; $display("FAIL climb_level got %0d want 3", levelCnt); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh !== 1'b1) begin fails++; $display("FAIL maxlevel_flag got %b want 1", bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh); end
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
`ifdef SC_SPEEDSCHEDULER_WRAP_EN
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b101) begin fails++; $display("FAIL wrap_state got %b want 101", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_clear_OutLow !== 1'b0) begin fails++; $display("FAIL wrap_clear got %b want 0", bus.SC_SPEEDSCHEDULER_clear_OutLow); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL wrap_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    @(negedge clk);
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b001) begin fails++; $display("FAIL wrap_run got %b want 001", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_clear_OutLow !== 1'b1) begin fails++; $display("FAIL wrap_clear_width got %b want 1", bus.SC_SPEEDSCHEDULER_clear_OutLow); end
    asserts++; if (levelCnt !== 8'd0) begin fails++; $display("FAIL wrap_level got %0d want 0", levelCnt); end
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      asserts++;
      if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== ((i % 10) == 0)) begin
        fails++; $display("FAIL wrap_period10_tick cycle %0d got %b want %b", i, bus.SC_SPEEDSCHEDULER_tick_OutHigh, (i % 10) == 0);
      end
    end
`else
    // Ignored request: prescaler kept counting, so this observation is count 1.
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b001) begin fails++; $display("FAIL ignored_state got %b want 001", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL ignored_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    for (int i = 2; i <= 12; i++) begin
      if (i > 2) @(negedge clk);
      asserts++;
      if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== ((i % 4) == 0)) begin
        fails++; $display("FAIL period4_tick cycle %0d got %b want %b", i, bus.SC_SPEEDSCHEDULER_tick_OutHigh, (i % 4) == 0);
      end
    end
    asserts++; if (levelCnt !== 8'd3) begin fails++; $display("FAIL ignored_level got %0d want 3", levelCnt); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh !== 1'b1) begin fails++; $display("FAIL ignored_maxlevel got %b want 1", bus.SC_SPEEDSCHEDULER_maxlevel_OutHigh); end
`endif
  endtask

  task automatic test_gameover_levelup();
    bus.SC_SPEEDSCHEDULER_gameover_InLow = 1'b0;
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_gameover_InLow = 1'b1;
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b100) begin fails++; $display("FAIL simul_state got %b want 100", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_clear_OutLow !== 1'b0) begin fails++; $display("FAIL simul_clear got %b want 0", bus.SC_SPEEDSCHEDULER_clear_OutLow); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL simul_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    @(negedge clk);
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b000) begin fails++; $display("FAIL simul_idle got %b want 000", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== 1'b0) begin fails++; $display("FAIL simul_tick got %b want 0", bus.SC_SPEEDSCHEDULER_tick_OutHigh); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_clear_OutLow !== 1'b1) begin fails++; $display("FAIL simul_clear_width got %b want 1", bus.SC_SPEEDSCHEDULER_clear_OutLow); end
    asserts++; if (levelCnt !== 8'd0) begin fails++; $display("FAIL simul_level got %0d want 0", levelCnt); end
    // IDLE ignores everything but start.
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
    bus.SC_SPEEDSCHEDULER_pause_InLow = 1'b0;
    bus.SC_SPEEDSCHEDULER_gameover_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
    bus.SC_SPEEDSCHEDULER_pause_InLow = 1'b1;
    bus.SC_SPEEDSCHEDULER_gameover_InLow = 1'b1;
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b000) begin fails++; $display("FAIL idle_ignore_state got %b want 000", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL idle_ignore_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
  endtask

  task automatic test_pause();
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b1;
    for (int i = 2; i <= 6; i++) @(negedge clk);
    bus.SC_SPEEDSCHEDULER_pause_InLow = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 10) bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
      if (j == 11) bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
      asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b010) begin fails++; $display("FAIL pause_state cycle %0d got %b want 010", j, bus.SC_SPEEDSCHEDULER_state_OutBUS); end
      asserts++; if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== 1'b0) begin fails++; $display("FAIL pause_tick cycle %0d got %b want 0", j, bus.SC_SPEEDSCHEDULER_tick_OutHigh); end
    end
    asserts++; if (levelCnt !== 8'd0) begin fails++; $display("FAIL pause_levelup_dropped got %0d want 0", levelCnt); end
    bus.SC_SPEEDSCHEDULER_pause_InLow = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      asserts++;
      if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== (j == 5)) begin
        fails++; $display("FAIL resume_tick cycle %0d got %b want %b", j, bus.SC_SPEEDSCHEDULER_tick_OutHigh, j == 5);
      end
    end
  endtask

  task automatic test_reset_in_levelup();
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_levelup_InLow = 1'b1;
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b0) begin fails++; $display("FAIL rstlu_pre_upcount got %b want 0", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    #1 rst = 1'b1;
    #1;
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL rstlu_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b000) begin fails++; $display("FAIL rstlu_state got %b want 000", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    @(negedge clk);
    asserts++; if (levelCnt !== 8'd0) begin fails++; $display("FAIL rstlu_level got %0d want 0", levelCnt); end
    rst = 1'b0;
    @(negedge clk);
    asserts++; if (bus.SC_SPEEDSCHEDULER_upcount_OutLow !== 1'b1) begin fails++; $display("FAIL rstlu_release_upcount got %b want 1", bus.SC_SPEEDSCHEDULER_upcount_OutLow); end
    asserts++; if (bus.SC_SPEEDSCHEDULER_state_OutBUS !== 3'b000) begin fails++; $display("FAIL rstlu_release_state got %b want 000", bus.SC_SPEEDSCHEDULER_state_OutBUS); end
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b0;
    @(negedge clk);
    bus.SC_SPEEDSCHEDULER_start_InLow = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) @(negedge clk);
      asserts++;
      if (bus.SC_SPEEDSCHEDULER_tick_OutHigh !== (i == 10)) begin
        fails++; $display("FAIL rstlu_restart_tick cycle %0d got %b want %b", i, bus.SC_SPEEDSCHEDULER_tick_OutHigh, i == 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_period();
    test_levelup();
    test_maxlevel();
    test_gameover_levelup();
    test_pause();
    test_reset_in_levelup();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/sc_speedscheduler.md
# sc_speedscheduler

Game-speed controller for the Frogger datapath. It sequences the up-speed counter by driving its active-low upcount and clear strobes from game events (start, level-up, game over, pause), and reads the counter value back as the current level. From that level it derives a lane-movement period and emits a one-cycle movement tick every period, so traffic speeds up as the level rises.

## Interface
- `BASE_PERIOD`, default 25_000_000: tick period at level 0, in clock cycles.
- `PERIOD_STEP`, default 2_000_000: period reduction per level.
- `MIN_PERIOD`, default 2_500_000: period floor; must be ≥2.
- `MAX_LEVEL`, default 8: highest level reachable by level-up.
- `DATAWIDTH`, default 8: level bus width; matches the speed counter.
- `PRESCALER_WIDTH`, default 26: prescaler width; must hold `BASE_PERIOD-1`.
- `SC_SPEEDSCHEDULER_CLOCK_50`  in  1  system clock, single clock domain.
- `SC_SPEEDSCHEDULER_RESET_InHigh`  in  1  reset, asynchronous, active-high.
- `SC_SPEEDSCHEDULER_start_InLow`  in  1  start game; sampled in IDLE only.
- `SC_SPEEDSCHEDULER_levelup_InLow`  in  1  frog reached goal; one-cycle low pulse.
- `SC_SPEEDSCHEDULER_gameover_InLow`  in  1  collision or time-out; one-cycle low pulse.
- `SC_SPEEDSCHEDULER_pause_InLow`  in  1  level-sensitive pause request.
- `SC_SPEEDSCHEDULER_level_InBUS`  in  DATAWIDTH  current value of the speed counter.
- `SC_SPEEDSCHEDULER_upcount_OutLow`  out  1  to counter upcount; low for exactly one cycle per accepted level-up.
- `SC_SPEEDSCHEDULER_clear_OutLow`  out  1  to counter clear; low for exactly one cycle per clear.
- `SC_SPEEDSCHEDULER_tick_OutHigh`  out  1  lane-move strobe; one-cycle pulse.
- `SC_SPEEDSCHEDULER_maxlevel_OutHigh`  out  1  high when `level_InBUS` ≥ `MAX_LEVEL`.
- `SC_SPEEDSCHEDULER_state_OutBUS`  out  3  FSM state, for debug and the HUD.

## Operation
- **States and encodings:** IDLE=000, RUN=001, PAUSE=010, LEVELUP=011, CLEAR=100, WRAP=101 (WRAP exists only with the macro).
- **IDLE:**
  - `start_InLow`=0 → RUN, with the prescaler loaded to 0.
  - All other inputs are ignored.
- **RUN priority, highest first:**
  - `gameover_InLow`=0 → CLEAR.
  - `levelup_InLow`=0 with level < `MAX_LEVEL` → LEVELUP.
  - `levelup_InLow`=0 with level ≥ `MAX_LEVEL` → ignored; see Configuration.
  - `pause_InLow`=0 → PAUSE.
  - Otherwise the prescaler advances.
- **LEVELUP:** one cycle. `upcount_OutLow`=0 and prescaler := 0. Next state is RUN.
- **CLEAR:** one cycle. `clear_OutLow`=0 and prescaler := 0. Next state is IDLE.
- **PAUSE:**
  - The prescaler holds its value and no ticks are issued.
  - `gameover_InLow`=0 → CLEAR.
  - `pause_InLow`=1 → RUN, resuming from the held count.
  - Level-up requests in PAUSE are dropped.
- **Period rule:**
  - period = max(`MIN_PERIOD`, `BASE_PERIOD` − level×`PERIOD_STEP`).
  - The subtraction is evaluated in `PRESCALER_WIDTH`+`DATAWIDTH`+1 bits, signed. It must never wrap; a negative result saturates to `MIN_PERIOD`.
- **Prescaler:**
  - In RUN it counts 0..period−1 and wraps to 0.
  - `tick_OutHigh` = (state==RUN) && (count==period−1).
  - If the level, and therefore the period, changes while count ≥ new period, the next cycle forces count to 0 with no tick.
- **Output decoding:** `upcount_OutLow`, `clear_OutLow` and `tick_OutHigh` are decoded from registered state and count only. They never depend combinationally on the event inputs.
- **Input handling:** event pulses must be synchronous and one cycle wide. A pulse held low longer is treated as repeated requests.

## Timing
- **Reset values** (reset asserted, or the first cycle after release):
  - state = IDLE, prescaler = 0.
  - `upcount_OutLow`=1, `clear_OutLow`=1, `tick_OutHigh`=0, `state_OutBUS`=000.
  - `maxlevel_OutHigh` follows `level_InBUS` combinationally; it is 0 when the counter is at 0.
- **Reset mid-operation:** takes effect immediately, asynchronously. Any strobe in progress is cut off, and no partial pulse may appear after release.
- **Level-up latency:**
  - Pulse sampled at edge k → LEVELUP during cycle k..k+1, with upcount low in that cycle.
  - The counter increments at edge k+1.
  - The new period applies from cycle k+1 onward, with count starting at 0.
- **First tick after entering RUN:** period cycles after entry; the tick appears in the cycle where count = period−1.
- **Simultaneous events:** gameover + levelup in the same cycle → CLEAR only; upcount stays high.

## Configuration
- `SC_SPEEDSCHEDULER_WRAP_EN` defined:
  - A level-up at level ≥ `MAX_LEVEL` → WRAP for one cycle.
  - In WRAP: `clear_OutLow`=0 and prescaler := 0, then back to RUN. The game loops to level 0 and keeps running.
- `SC_SPEEDSCHEDULER_WRAP_EN` undefined:
  - The same request is ignored; the FSM stays in RUN and the prescaler is undisturbed.
  - WRAP is unreachable and its encoding decodes as IDLE.

## Test plan
Bench parameters: `BASE_PERIOD`=10, `PERIOD_STEP`=2, `MIN_PERIOD`=4, `MAX_LEVEL`=3, `DATAWIDTH`=8, `PRESCALER_WIDTH`=8. The bench includes a behavioural up-counter wired to upcount, clear and level.
- Reset, then a 1-cycle start pulse → state 001; `tick_OutHigh` pulses exactly once every 10 cycles; first tick in the 10th RUN cycle.
- Level-up at level 0 → state 011 for 1 cycle, upcount low for exactly 1 cycle, level = 1, ticks every 8 cycles from prescaler 0.
- Levels 0→3, then one more level-up:
  - Without the macro: no upcount, maxlevel = 1, ticks stay at period 4.
  - With the macro: state 101, clear low for 1 cycle, level = 0, period 10.
- Pause held low for 20 cycles with count = 5 → no ticks and count frozen. After release, the tick falls in the 5th cycle.
- Gameover and level-up low in the same RUN cycle → state 100 for 1 cycle, clear low for 1 cycle, upcount never low, then state 000 with tick = 0.
- Reset asserted during LEVELUP → same cycle: upcount = 1, state 000, prescaler 0. The level counter stays unincremented.
